// File: rtl/ld_cell_ctrl_pkg.sv
// Shared types and constants for the rider-detect load-cell sequencer.
// Holds the sequencer state enum, A2D channel codes, default thresholds
// and the settle-timer width helper. Note: MIN_RIDER_WEIGHT - HYSTERESIS must not underflow.
package ld_cell_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ_L  = 2'd0,
    REQ_R  = 2'd1,
    UPDATE = 2'd2,
    GAP    = 2'd3
  } ld_state_t;

  localparam logic [2:0] LFT_CHNL  = 3'b000;
  localparam logic [2:0] RGHT_CHNL = 3'b100;

  localparam logic [11:0] DFLT_MIN_RIDER_WEIGHT = 12'h200;
  localparam logic [11:0] DFLT_HYSTERESIS       = 12'h040;

  // Full-size timer is ~1.34 s at 50 MHz; the short one keeps sims quick.
  function automatic int tmr_width(input bit fast_sim);
    return fast_sim ? 15 : 26;
  endfunction

endpackage

// File: rtl/ld_cell_ctrl_if.sv
// Request/ready conversion interface between the sequencer and the A2D.
// Ports: a2d_req/a2d_chnl from the requester, a2d_rdy/a2d_res back from the A2D.
// Requester holds a2d_req and a2d_chnl until a one-cycle a2d_rdy pulse.
interface ld_cell_ctrl_if;
  logic        a2d_req;
  logic [2:0]  a2d_chnl;
  logic        a2d_rdy;
  logic [11:0] a2d_res;

  modport master (
    output a2d_req,
    output a2d_chnl,
    input  a2d_rdy,
    input  a2d_res
  );

  modport slave (
    input  a2d_req,
    input  a2d_chnl,
    output a2d_rdy,
    output a2d_res
  );
endinterface

// File: rtl/ld_cell_ctrl_settle_tmr.sv
// Saturating rider-settle timer; full when the counter is all-ones.
// Ports: clk, rst (sync, active-high), clr (sync clear, wins over count), full.
// Latency: clr takes effect on the next edge; no backpressure.
module settle_tmr
  import ld_cell_ctrl_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic full
);

  localparam int W = tmr_width(FAST_SIM);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!full) begin
      cnt <= cnt + W'(1);
    end
  end

  assign full = &cnt;

endmodule

// File: rtl/ld_cell_ctrl.sv
// Round-robin left/right load-cell sequencer with rider hysteresis/diff flags.
// Ports: clk, rst (sync, active-high), a2d (master), clr_tmr, readings, flags, tmr_full, vld.
// Latency: flags/vld one edge after right capture; a2d_req held until a2d_rdy.
module ld_cell_ctrl
  import ld_cell_ctrl_pkg::*;
#(
  parameter logic [11:0] MIN_RIDER_WEIGHT = DFLT_MIN_RIDER_WEIGHT,
  parameter logic [11:0] HYSTERESIS       = DFLT_HYSTERESIS,
  parameter int unsigned SAMPLE_GAP       = 1024,
  parameter bit          FAST_SIM         = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  ld_cell_ctrl_if.master a2d,
  input  logic           clr_tmr,
  output logic [11:0]    lft_ld,
  output logic [11:0]    rght_ld,
  output logic           sum_gt_min,
  output logic           sum_lt_min,
  output logic           diff_gt_1_4,
  output logic           diff_gt_15_16,
  output logic           tmr_full,
  output logic           vld
);

  localparam int GAP_W = $clog2(SAMPLE_GAP + 1);

  localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};

  ld_state_t        state;
  logic [GAP_W-1:0] gap_cnt;

  logic [12:0] sum;
  logic [11:0] diff;
  logic        rdy_ok;

  assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);

  // A ready only counts against a live request; this drops a stale ready
  // that lands in the first cycle after reset, before a2d_req has risen.
  assign rdy_ok = a2d.a2d_rdy && a2d.a2d_req;

  // a2d_req/a2d_chnl are assigned alongside each state transition, so they
  // reflect the state being entered and change only on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= REQ_L;
      gap_cnt       <= '0;
      a2d.a2d_req   <= 1'b0;
      a2d.a2d_chnl  <= LFT_CHNL;
      lft_ld        <= '0;
      rght_ld       <= '0;
      sum_gt_min    <= 1'b0;
      sum_lt_min    <= 1'b1;
      diff_gt_1_4   <= 1'b0;
      diff_gt_15_16 <= 1'b0;
      vld           <= 1'b0;
    end else begin
      unique case (state)
        REQ_L: begin
          a2d.a2d_req <= 1'b1;
          if (rdy_ok) begin
            lft_ld       <= a2d.a2d_res;
            state        <= REQ_R;
            a2d.a2d_chnl <= RGHT_CHNL;
          end else begin
            a2d.a2d_chnl <= LFT_CHNL;
          end
        end
        REQ_R: begin
          a2d.a2d_chnl <= RGHT_CHNL;
          if (rdy_ok) begin
            rght_ld     <= a2d.a2d_res;
            state       <= UPDATE;
            a2d.a2d_req <= 1'b0;
          end else begin
            a2d.a2d_req <= 1'b1;
          end
        end
        UPDATE: begin
          sum_gt_min    <= sum > THR_HI;
          sum_lt_min    <= sum < THR_LO;
          diff_gt_1_4   <= {1'b0, diff} > (sum >> 2);
          diff_gt_15_16 <= {1'b0, diff} > (sum - (sum >> 4));
          vld           <= 1'b1;
          // Loaded with the full gap so REQ_L is re-entered SAMPLE_GAP+1 edges later.
          gap_cnt       <= GAP_W'(SAMPLE_GAP);
          state         <= GAP;
          a2d.a2d_req   <= 1'b0;
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state        <= REQ_L;
            a2d.a2d_req  <= 1'b1;
            a2d.a2d_chnl <= LFT_CHNL;
          end else begin
            gap_cnt      <= gap_cnt - GAP_W'(1);
            a2d.a2d_req  <= 1'b0;
          end
        end
      endcase
    end
  end

  settle_tmr #(
    .FAST_SIM (FAST_SIM)
  ) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_tmr),
    .full (tmr_full)
  );

endmodule

// File: tb/tb_ld_cell_ctrl.sv
// Self-checking bench for ld_cell_ctrl with a behavioural A2D and flag model.
// Ports: none; drives the DUT through an ld_cell_ctrl_if instance.
// A2D responds with random 0..3 cycle latency after each request.
module tb_ld_cell_ctrl;
  import ld_cell_ctrl_pkg::*;

  localparam int MIN_W = 'h200;
  localparam int HYS   = 'h040;
  localparam int GAP_C = 4;

  logic clk;
  logic rst;
  logic clr_tmr;
  logic [11:0] lft_ld, rght_ld;
  logic sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full, vld;

  ld_cell_ctrl_if a2d();

  ld_cell_ctrl #(
    .MIN_RIDER_WEIGHT (12'h200),
    .HYSTERESIS       (12'h040),
    .SAMPLE_GAP       (GAP_C),
    .FAST_SIM         (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .a2d           (a2d),
    .clr_tmr       (clr_tmr),
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_1_4   (diff_gt_1_4),
    .diff_gt_15_16 (diff_gt_15_16),
    .tmr_full      (tmr_full),
    .vld           (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [3:0] prev_flags;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flag model: {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}.
  function automatic logic [3:0] ref_flags(input int l, input int r);
    int s, d;
    s = l + r;
    d = (l > r) ? l - r : r - l;
    return {s > MIN_W + HYS, s < MIN_W - HYS, d > s / 4, d > s - s / 16};
  endfunction

  function automatic logic [3:0] obs_flags();
    return {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16};
  endfunction

  // Entered at a sample point; leaves at the sample point where the next
  // left request is first visible.
  task automatic run_pair(input logic [11:0] l, input logic [11:0] r);
    int n;
    int lat;
    logic [3:0] exp_f;
    n = 0;
    while (!a2d.a2d_req && n < 100) begin
      step();
      n++;
    end
    chk("req_l_seen", 32'(a2d.a2d_req), 32'd1);
    chk("chnl_l", 32'(a2d.a2d_chnl), 32'(LFT_CHNL));
    lat = $urandom_range(0, 3);
    repeat (lat) step();
    a2d.a2d_rdy = 1'b1;
    a2d.a2d_res = l;
    step();
    a2d.a2d_rdy = 1'b0;
    a2d.a2d_res = 12'($urandom);
    chk("lft_ld", 32'(lft_ld), 32'(l));
    chk("req_r_held", 32'(a2d.a2d_req), 32'd1);
    chk("chnl_r", 32'(a2d.a2d_chnl), 32'(RGHT_CHNL));
    chk("flags_hold", 32'(obs_flags()), 32'(prev_flags));
    lat = $urandom_range(0, 3);
    repeat (lat) step();
    chk("chnl_r_stable", 32'(a2d.a2d_chnl), 32'(RGHT_CHNL));
    a2d.a2d_rdy = 1'b1;
    a2d.a2d_res = r;
    step();
    a2d.a2d_rdy = 1'b0;
    a2d.a2d_res = 12'($urandom);
    chk("rght_ld", 32'(rght_ld), 32'(r));
    chk("req_drop", 32'(a2d.a2d_req), 32'd0);
    step();
    exp_f = ref_flags(int'(l), int'(r));
    chk("flags", 32'(obs_flags()), 32'(exp_f));
    chk("vld", 32'(vld), 32'd1);
    prev_flags = exp_f;
    n = 0;
    while (!a2d.a2d_req && n < 100) begin
      step();
      n++;
    end
    chk("gap_len", 32'(n), 32'(GAP_C + 1));
  endtask

  logic [11:0] dl [8];
  logic [11:0] dr [8];

  initial begin
    int n;
    logic [11:0] l, r;
    dl = '{12'h180, 12'h0F0, 12'h0A0, 12'h300, 12'h3F0, 12'h120, 12'h0E0, 12'h0A0};
    dr = '{12'h180, 12'h0F0, 12'h0A0, 12'h080, 12'h000, 12'h120, 12'h0E0, 12'h060};

    rst = 1'b1;
    clr_tmr = 1'b0;
    a2d.a2d_rdy = 1'b0;
    a2d.a2d_res = '0;
    step();
    step();
    chk("rst_req", 32'(a2d.a2d_req), 32'd0);
    chk("rst_chnl", 32'(a2d.a2d_chnl), 32'd0);
    chk("rst_lft", 32'(lft_ld), 32'd0);
    chk("rst_rght", 32'(rght_ld), 32'd0);
    chk("rst_flags", 32'(obs_flags()), 32'b0100);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_tmr", 32'(tmr_full), 32'd0);
    prev_flags = 4'b0100;
    rst = 1'b0;
    step();
    chk("first_req", 32'(a2d.a2d_req), 32'd1);

    for (int i = 0; i < 8; i++) run_pair(dl[i], dr[i]);
    for (int i = 0; i < 24; i++) begin
      l = (i % 2 == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 'h200));
      r = (i % 5 == 0) ? 12'h000 : 12'($urandom_range(0, 'h200));
      run_pair(l, r);
    end

    // Reset while waiting on the right conversion, then a stale ready.
    a2d.a2d_rdy = 1'b1;
    a2d.a2d_res = 12'h155;
    step();
    a2d.a2d_rdy = 1'b0;
    chk("mr_in_req_r", 32'(a2d.a2d_chnl), 32'(RGHT_CHNL));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_req", 32'(a2d.a2d_req), 32'd0);
    chk("mr_lft", 32'(lft_ld), 32'd0);
    chk("mr_vld", 32'(vld), 32'd0);
    chk("mr_flags", 32'(obs_flags()), 32'b0100);
    a2d.a2d_rdy = 1'b1;
    a2d.a2d_res = 12'h7AB;
    step();
    a2d.a2d_rdy = 1'b0;
    chk("mr_lft_ign", 32'(lft_ld), 32'd0);
    chk("mr_rght_ign", 32'(rght_ld), 32'd0);
    chk("mr_req_up", 32'(a2d.a2d_req), 32'd1);
    chk("mr_chnl", 32'(a2d.a2d_chnl), 32'(LFT_CHNL));
    prev_flags = 4'b0100;
    run_pair(12'h210, 12'h1F0);

    // Settle timer: A2D left unanswered from here on.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("tmr_rst", 32'(tmr_full), 32'd0);
    n = 0;
    while (!tmr_full && n < 40000) begin
      step();
      n++;
    end
    chk("tmr_rise", 32'(n), 32'd32767);
    repeat (3) step();
    chk("tmr_stay", 32'(tmr_full), 32'd1);
    clr_tmr = 1'b1;
    step();
    clr_tmr = 1'b0;
    chk("tmr_clr", 32'(tmr_full), 32'd0);
    n = 0;
    while (!tmr_full && n < 40000) begin
      step();
      n++;
    end
    chk("tmr_rise2", 32'(n), 32'd32767);
    clr_tmr = 1'b1;
    step();
    clr_tmr = 1'b0;
    chk("tmr_clr_sat", 32'(tmr_full), 32'd0);
    chk("tmr_cnt_zero", 32'(dut.u_tmr.cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
